mul_sched: RTL and testbench
============================

# mul_sched

Round-robin scheduler that shares one `booth_32` signed 32×32 multiplier core among `NREQ` requesters.

- Accepts requests with a valid/ready handshake.
- Registers the operands and sequences the core's `start` pulse.
- Waits a fixed core latency, then returns the 64-bit product tagged with the requester id.
- Sits between the processing clients and the multiplier core. It is the only block that drives the core's inputs.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `MUL_WAIT`, 34: cycles spent in `BUSY` (core start sample to final product registered, plus one).

Ports:
- `clk`, input, 1: clock.
- `n_rst`, input, 1: reset, asynchronous, active-low. Also drives the core's `n_rst`.
- `req_valid`, input, NREQ: per-requester request valid.
- `req_ready`, output, NREQ: one-hot grant/accept. Reset value 0.
- `req_m`, input, NREQ*32: multiplicands, packed; requester i at `[32i+31:32i]`.
- `req_q`, input, NREQ*32: multipliers, packed the same way.
- `rsp_valid`, output, 1: product available. Reset value 0.
- `rsp_ready`, input, 1: consumer accepts the product.
- `rsp_id`, output, `$clog2(NREQ)`: index of the requester that owns the product. Reset value 0.
- `rsp_data`, output, 64: signed product. Reset value 0.

## Operation
FSM states are `IDLE`, `START`, `BUSY`, `RESP`. Reset state is `IDLE`.
- `IDLE`
  - `req_ready` is the round-robin grant: the first asserted `req_valid` at or after `rr_ptr`, wrapping modulo `NREQ`. It is combinational from `req_valid`.
  - On a handshake: latch `m_r`, `q_r`, `id_r`; set `rr_ptr` = granted+1 (mod `NREQ`); go to `START`.
  - With no `req_valid`, stay in `IDLE`.
- `START`
  - Core `start`=1 for exactly this one cycle.
  - Load `cnt`=`MUL_WAIT`-1; go to `BUSY`.
- `BUSY`
  - Core `start`=0; `cnt` decrements each cycle.
  - At `cnt`==0: register the core result into `rsp_data`, set `rsp_valid`=1, `rsp_id`=`id_r`; go to `RESP`.
- `RESP`
  - Hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_ready`.
  - On the handshake: clear `rsp_valid`; go to `IDLE`.
- The core's M and Q inputs are driven from `m_r`/`q_r` and are stable from `START` through `BUSY`.
- Operand fix-up, applied at latch time:
  - The core cannot handle M = 32'h8000_0000.
  - If `req_m`==32'h8000_0000 and `req_q`!=32'h8000_0000, swap the operands.
  - If both operands are 32'h8000_0000, set `fix_r`. The core still runs and latency is unchanged, but `rsp_data` is forced to 64'h4000_0000_0000_0000.
- `rr_ptr` resets to 0. Requesters not granted keep `req_valid` asserted; the block never drops a pending request.
- `req_ready` is 0 in `START`, `BUSY` and `RESP`. Only one operation is in flight.

## Timing
- Request accepted at clock edge E0 → `rsp_valid` rises at E0+`MUL_WAIT`+1 (E35 with the default).
- `rsp_ready` already high when `rsp_valid` rises → response handshake at the next edge, `IDLE` on the following cycle.
- The next request can be accepted at the earliest one cycle after the response handshake. Minimum issue interval is `MUL_WAIT`+3 cycles (37).
- A request and a response handshake never occur in the same cycle.
- Reset mid-operation:
  - All state clears asynchronously, including the core, so no stale product is emitted.
  - `rsp_valid` and `req_ready` go 0 immediately.

## Configuration
- `MUL_SCHED_STATS_EN`
  - Defined: adds output `stat_ops` (32-bit, increments on each response handshake) and output `stat_busy` (32-bit, increments every cycle the state is not `IDLE`). Both are reset to 0 and saturate at all-ones.
  - Undefined: neither port nor the counters exist.

## Structure
- Shared package `mul_pkg`:
  - state enum (`IDLE`, `START`, `BUSY`, `RESP`);
  - `MUL_W`=32, `PROD_W`=64;
  - `MUL_WAIT_DEF`=34;
  - constants `M_NEG_MAX`=32'h8000_0000 and `P_NEG_SQ`=64'h4000_0000_0000_0000.
- One sub-module: a `booth_32` instance, `u_booth`. The round-robin grant stays inline.

## Test plan
- Single request: requester 2 sends m=7, q=-3 → `rsp_data`=64'hFFFF_FFFF_FFFF_FFEB, `rsp_id`=2, `rsp_valid` at E0+35.
- All four requesters valid continuously from reset → grants in order 0,1,2,3,0; each `rsp_id` matches its grant.
- m=32'h8000_0000, q=5 → swap path gives `rsp_data`=64'hFFFF_FFFD_8000_0000. m=q=32'h8000_0000 → `rsp_data`=64'h4000_0000_0000_0000.
- `rsp_ready` held low for 10 cycles → `rsp_valid`/`rsp_data` stable, `req_ready` stays 0 throughout, the next grant comes only after the handshake.
- `n_rst` asserted in `BUSY` cycle 10 → outputs 0 immediately. After release, a new m=3, q=4 returns 12 with normal latency.
- With `MUL_SCHED_STATS_EN` defined, 3 back-to-back ops with `rsp_ready`=1 → `stat_ops`=3, `stat_busy`=108.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the mul_sched multiplier scheduler
// and its booth_32 core.
package mul_pkg;
  localparam int unsigned MUL_W        = 32;
  localparam int unsigned PROD_W       = 64;
  localparam int unsigned MUL_WAIT_DEF = 34;

  localparam logic [MUL_W-1:0]  M_NEG_MAX = 32'h8000_0000;
  localparam logic [PROD_W-1:0] P_NEG_SQ  = 64'h4000_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } state_e;
endpackage

// File: rtl/mul_sched_if.sv
// Requester/response bundle of mul_sched. The master modport is the client
// side and the slave modport is the scheduler side.
interface mul_sched_if #(
  parameter int unsigned NREQ = 4
);
  import mul_pkg::*;

  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*MUL_W-1:0] req_m;
  logic [NREQ*MUL_W-1:0] req_q;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [PROD_W-1:0]     rsp_data;

  modport master (
    output req_valid, req_m, req_q, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_m, req_q, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/booth_32.sv
// Iterative radix-2 Booth signed 32x32 multiplier: start loads Q, then one
// recoding step per cycle for 32 cycles. M must stay stable while it runs.
module booth_32
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [MUL_W-1:0]  m,
  input  logic [MUL_W-1:0]  q,
  output logic [PROD_W-1:0] product
);
  logic [MUL_W:0]   a_q;
  logic [MUL_W:0]   a_d;
  logic [MUL_W-1:0] qr_q;
  logic             q1_q;
  logic [5:0]       cnt_q;
  logic [MUL_W:0]   m_ext;

  assign m_ext = {m[MUL_W-1], m};

  always_comb begin
    a_d = a_q;
    case ({qr_q[0], q1_q})
      2'b01:   a_d = a_q + m_ext;
      2'b10:   a_d = a_q - m_ext;
      default: a_d = a_q;
    endcase
  end

  // Arithmetic right shift of {A, Q, q-1}; A carries a guard bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q   <= '0;
      qr_q  <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      a_q   <= '0;
      qr_q  <= q;
      q1_q  <= 1'b0;
      cnt_q <= 6'd32;
    end else if (cnt_q != '0) begin
      a_q   <= {a_d[MUL_W], a_d[MUL_W:1]};
      qr_q  <= {a_d[0], qr_q[MUL_W-1:1]};
      q1_q  <= qr_q[0];
      cnt_q <= cnt_q - 6'd1;
    end
  end

  assign product = {a_q[MUL_W-1:0], qr_q};
endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one booth_32 core among NREQ requesters.
// Optional activity counters are enabled with MUL_SCHED_STATS_EN.
module mul_sched
  import mul_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MUL_WAIT = MUL_WAIT_DEF
) (
  input  logic        clk,
  input  logic        n_rst,
`ifdef MUL_SCHED_STATS_EN
  output logic [31:0] stat_ops,
  output logic [31:0] stat_busy,
`endif
  mul_sched_if.slave  bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(MUL_WAIT + 1);

  state_e            state_q;
  logic [IDW-1:0]    rr_q;
  logic [IDW-1:0]    id_q;
  logic [MUL_W-1:0]  m_q;
  logic [MUL_W-1:0]  q_q;
  logic              fix_q;
  logic [CW-1:0]     cnt_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [PROD_W-1:0] rsp_data_q;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic [IDW-1:0]    rr_d;
  logic [MUL_W-1:0]  sel_m;
  logic [MUL_W-1:0]  sel_q;
  logic [MUL_W-1:0]  m_d;
  logic [MUL_W-1:0]  q_d;
  logic              fix_d;
  logic [PROD_W-1:0] core_p;

  // First valid requester at or after rr_q, wrapping modulo NREQ.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (gnt == '0 && bus.req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx[IDW-1:0];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE && n_rst) ? gnt : '0;
  assign rr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  // The core cannot take M = -2^31: swap it into Q, or flag the -2^31 squared case.
  always_comb begin
    sel_m = bus.req_m[int'(gnt_id)*MUL_W +: MUL_W];
    sel_q = bus.req_q[int'(gnt_id)*MUL_W +: MUL_W];
    m_d   = sel_m;
    q_d   = sel_q;
    fix_d = 1'b0;
    if (sel_m == M_NEG_MAX) begin
      if (sel_q == M_NEG_MAX) begin
        fix_d = 1'b1;
      end else begin
        m_d = sel_q;
        q_d = sel_m;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      m_q         <= '0;
      q_q         <= '0;
      fix_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt != '0) begin
            m_q     <= m_d;
            q_q     <= q_d;
            fix_q   <= fix_d;
            id_q    <= gnt_id;
            rr_q    <= rr_d;
            state_q <= START;
          end
        end
        START: begin
          cnt_q   <= CW'(MUL_WAIT - 1);
          state_q <= BUSY;
        end
        BUSY: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= fix_q ? P_NEG_SQ : core_p;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

  booth_32 u_booth (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (state_q == START),
    .m       (m_q),
    .q       (q_q),
    .product (core_p)
  );

`ifdef MUL_SCHED_STATS_EN
  logic [31:0] stat_ops_q;
  logic [31:0] stat_busy_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stat_ops_q  <= '0;
      stat_busy_q <= '0;
    end else begin
      if (state_q == RESP && bus.rsp_ready && stat_ops_q != '1)
        stat_ops_q <= stat_ops_q + 32'd1;
      if (state_q != IDLE && stat_busy_q != '1)
        stat_busy_q <= stat_busy_q + 32'd1;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_busy = stat_busy_q;
`endif
endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched: vector table of single requests plus
// round-robin, response back-pressure and mid-operation reset sequences.
module tb_mul_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 35;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;
  int   cyc;

`ifdef MUL_SCHED_STATS_EN
  logic [31:0] stat_ops;
  logic [31:0] stat_busy;
`endif

  mul_sched_if #(.NREQ(NREQ)) bus ();

  mul_sched #(.NREQ(NREQ), .MUL_WAIT(34)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
`ifdef MUL_SCHED_STATS_EN
    .stat_ops  (stat_ops),
    .stat_busy (stat_busy),
`endif
    .bus       (bus)
  );

  typedef struct {
    int          id;
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_single(input int id, input logic [31:0] m, input logic [31:0] q,
                            input logic [63:0] exp, input string nm);
    int n;
    logic [3:0] oh;
    oh = 4'b0001 << id;
    bus.req_m[32*id +: 32] = m;
    bus.req_q[32*id +: 32] = q;
    bus.rsp_ready = 1'b1;
    bus.req_valid = oh;
    #1;
    check({nm, "_grant"}, 64'(bus.req_ready), 64'(oh));
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(n);
    check({nm, "_latency"}, 64'(n), 64'(LAT));
    check({nm, "_data"}, bus.rsp_data, exp);
    check({nm, "_id"}, 64'(bus.rsp_id), 64'(id));
    @(posedge clk); #1;
    check({nm, "_rsp_clear"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    int n;
    int hs_prev;
    int exp_id;

    vecs[0] = '{2, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{0, 32'h8000_0000,  32'd5,         64'hFFFF_FFFD_8000_0000};
    vecs[2] = '{1, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{3, 32'd5,          32'h8000_0000, 64'hFFFF_FFFD_8000_0000};
    vecs[4] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[5] = '{1, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[6] = '{2, 32'h1234_5678,  32'd0,         64'h0000_0000_0000_0000};
    vecs[7] = '{3, 32'h7FFF_FFFF,  32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[8] = '{0, 32'h0001_0000,  32'h0001_0000, 64'h0000_0001_0000_0000};
    vecs[9] = '{2, 32'hFFFF_FC18,  32'd1000,      64'hFFFF_FFFF_FFF0_BDC0};

    checks = 0;
    failures = 0;
    cyc = 0;
    n_rst = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_m = '0;
    bus.req_q = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rst_rsp_data", bus.rsp_data, 64'd0);

    // Round-robin: all requesters valid from reset.
    for (int i = 0; i < NREQ; i++) begin
      bus.req_m[32*i +: 32] = 32'(i + 2);
      bus.req_q[32*i +: 32] = 32'd1000;
    end
    bus.rsp_ready = 1'b1;
    #3;
    n_rst = 1'b1;
    #1;
    hs_prev = 0;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % NREQ;
      for (int t = 0; t < 100; t++) begin
        if (bus.req_ready != '0) break;
        @(posedge clk); #1;
      end
      check($sformatf("rr%0d_grant", k), 64'(bus.req_ready), 64'(4'b0001 << exp_id));
      @(posedge clk); #1;
      if (k > 0) check($sformatf("rr%0d_interval", k), 64'(cyc - hs_prev), 64'd37);
      hs_prev = cyc;
      if (k == 4) bus.req_valid = '0;
      wait_rsp(n);
      check($sformatf("rr%0d_latency", k), 64'(n), 64'(LAT));
      check($sformatf("rr%0d_id", k), 64'(bus.rsp_id), 64'(exp_id));
      check($sformatf("rr%0d_data", k), bus.rsp_data, 64'(exp_id + 2) * 64'd1000);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 10; i++)
      run_single(vecs[i].id, vecs[i].m, vecs[i].q, vecs[i].exp, $sformatf("vec%0d", i));

    // Back-pressure: rsp_ready low for 10 cycles with requester 3 pending.
    bus.rsp_ready = 1'b0;
    bus.req_m[32 +: 32] = 32'd6;
    bus.req_q[32 +: 32] = 32'd7;
    bus.req_m[96 +: 32] = 32'd2;
    bus.req_q[96 +: 32] = 32'd3;
    bus.req_valid = 4'b0010;
    #1;
    check("hold_grant1", 64'(bus.req_ready), 64'b0010);
    @(posedge clk); #1;
    bus.req_valid = 4'b1000;
    check("hold_no_grant_start", 64'(bus.req_ready), 64'd0);
    wait_rsp(n);
    check("hold_latency", 64'(n), 64'(LAT));
    check("hold_id", 64'(bus.rsp_id), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold%0d_valid", i), 64'(bus.rsp_valid), 64'd1);
      check($sformatf("hold%0d_data", i), bus.rsp_data, 64'd42);
      check($sformatf("hold%0d_req_ready", i), 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_rsp_clear", 64'(bus.rsp_valid), 64'd0);
    check("hold_next_grant", 64'(bus.req_ready), 64'b1000);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(n);
    check("hold_next_latency", 64'(n), 64'(LAT));
    check("hold_next_id", 64'(bus.rsp_id), 64'd3);
    check("hold_next_data", bus.rsp_data, 64'd6);
    @(posedge clk); #1;

    // Reset in BUSY cycle 10 with another requester waiting.
    bus.req_m[0 +: 32] = 32'd9;
    bus.req_q[0 +: 32] = 32'd9;
    bus.req_valid = 4'b0001;
    #1;
    check("mrst_grant", 64'(bus.req_ready), 64'b0001);
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    repeat (11) @(posedge clk);
    #1;
    check("mrst_busy_req_ready", 64'(bus.req_ready), 64'd0);
    n_rst = 1'b0;
    #1;
    check("mrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mrst_req_ready", 64'(bus.req_ready), 64'd0);
    check("mrst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("mrst_rsp_data", bus.rsp_data, 64'd0);
    repeat (3) @(posedge clk);
    bus.req_valid = '0;
    #3;
    n_rst = 1'b1;
    run_single(1, 32'd3, 32'd4, 64'd12, "post_rst");
    run_single(2, 32'hFFFF_FFFB, 32'd6, 64'hFFFF_FFFF_FFFF_FFE2, "post_rst2");
    run_single(3, 32'd100, 32'd100, 64'd10000, "post_rst3");
`ifdef MUL_SCHED_STATS_EN
    check("stat_ops", 64'(stat_ops), 64'd3);
    check("stat_busy", 64'(stat_busy), 64'd108);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
